prog_feeder: RTL

//  Instruction source for the base processor's control_unit. Holds a small program
//  (loaded through a write port) and issues instructions one at a time on din/run.

---
 rtl/prog_feeder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/prog_feeder.sv
// Program store and instruction issuer for control_unit: one run pulse per instruction, mvi immediate follows.
// Latency: start or done edge -> run the next cycle; backpressure: nothing new issues until done (or the watchdog trips).
module prog_feeder #(
    parameter int DATA_W  = 9,
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              abort,
    input  logic              done,
    output logic              run,
    output logic [DATA_W-1:0] din,
    output logic              busy,
    output logic [ADDR_W:0]   pc,
    output logic              fin,
    output logic              err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
    localparam logic [ADDR_W:0]  PC_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]  PC_TWO  = (ADDR_W+1)'(2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_IMM   = 3'd2,
        S_WAIT  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                run_q, run_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                busy_q, busy_d;
    logic [ADDR_W:0]     pc_q, pc_d;
    logic                fin_q, fin_d;
    logic                err_q, err_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [ADDR_W:0]     len_q, len_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_dat;
    logic [ADDR_W:0]     pc_inc1;
    logic [ADDR_W:0]     pc_nxt;
    logic                is_mvi;

    always_ff @(posedge clk) begin
        if (prog_we && !busy_q) begin
            mem[prog_addr] <= prog_data;
        end
    end

    assign pc_inc1 = pc_q + PC_ONE;
    assign pc_nxt  = (state_q == S_IMM) ? (pc_q + PC_TWO) : pc_inc1;
    assign is_mvi  = (din_q[DATA_W-1 -: 3] == 3'b001);

    // One read port, steered to whichever word the next transition may load.
    always_comb begin
        rd_addr = '0;
        case (state_q)
            S_ISSUE:       rd_addr = pc_inc1[ADDR_W-1:0];
            S_IMM, S_WAIT: rd_addr = pc_nxt[ADDR_W-1:0];
            default:       rd_addr = '0;
        endcase
    end

    assign rd_dat = mem[rd_addr];

    always_comb begin
        state_d = state_q;
        run_d   = 1'b0;
        din_d   = din_q;
        pc_d    = pc_q;
        fin_d   = 1'b0;
        wd_d    = wd_q;
        len_d   = len_q;
        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    pc_d  = '0;
                    len_d = prog_len;
                    wd_d  = '0;
                    if (prog_len == '0) begin
                        state_d = S_IDLE;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        run_d   = 1'b1;
                        din_d   = rd_dat;
                    end
                end
            end
            S_ISSUE: begin
                wd_d = '0;
                if (is_mvi) begin
                    if (pc_inc1 >= len_q) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_IMM;
                        din_d   = rd_dat;
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_IMM, S_WAIT: begin
                if (done) begin
                    pc_d = pc_nxt;
                    if (pc_nxt >= len_q) begin
                        state_d = S_IDLE;
                        fin_d   = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        run_d   = 1'b1;
                        din_d   = rd_dat;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ERR;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything but leaves pc and din where they were.
        if (abort) begin
            state_d = S_IDLE;
            run_d   = 1'b0;
            din_d   = din_q;
            pc_d    = pc_q;
            fin_d   = 1'b0;
            wd_d    = '0;
        end
        busy_d = (state_d == S_ISSUE) || (state_d == S_IMM) || (state_d == S_WAIT);
        err_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            pc_q    <= '0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            pc_q    <= pc_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            len_q   <= len_d;
        end
    end

    assign run  = run_q;
    assign din  = din_q;
    assign busy = busy_q;
    assign pc   = pc_q;
    assign fin  = fin_q;
    assign err  = err_q;
endmodule
